ldtu_ser_lane: RTL and testbench

//  One output lane downstream of the DTU datapath. Takes the 32-bit words the DTU

---
 rtl/ldtu_ser_lane_if.sv | 33 +++
 rtl/ldtu_ser_lane.sv | 83 ++++++++
 tb/tb_ldtu_ser_lane.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ldtu_ser_lane_if.sv
// DTU-to-lane bus: parallel word plus strobe in, serial bit stream and status pulses out.
// SER_ERR_CNT_EN adds the saturating underrun counter to the bus.
interface ldtu_ser_lane_if #(
  parameter int NBITS = 32
);
  logic [NBITS-1:0] DataIn;
  logic             handshake;
  logic             DataOut;
  logic             word_start;
  logic             underrun;
  logic             overrun;
`ifdef SER_ERR_CNT_EN
  logic [7:0]       underrun_cnt;

  modport master (
    output DataIn, handshake,
    input  DataOut, word_start, underrun, overrun, underrun_cnt
  );
  modport slave (
    input  DataIn, handshake,
    output DataOut, word_start, underrun, overrun, underrun_cnt
  );
`else
  modport master (
    output DataIn, handshake,
    input  DataOut, word_start, underrun, overrun
  );
  modport slave (
    input  DataIn, handshake,
    output DataOut, word_start, underrun, overrun
  );
`endif
endinterface

// File: rtl/ldtu_ser_lane.sv
// Double-buffered MSB-first serializer lane; substitutes IDLE_WORD when no word is pending.
// Optional feature macro: SER_ERR_CNT_EN (saturating 8-bit underrun counter).
module ldtu_ser_lane #(
  parameter int               NBITS     = 32,
  parameter logic [NBITS-1:0] IDLE_WORD = 32'hEAAAAAAA
) (
  input logic            clock,
  input logic            rst_b,
  ldtu_ser_lane_if.slave lane
);

  localparam int            CW   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  logic [NBITS-1:0] sh;
  logic [NBITS-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             holdValid;
  logic             armed;
  logic             hsS1;
  logic             hsS2;
  logic             hsS3;
  logic             cap;
  logic             boundary;

  assign cap          = hsS2 & ~hsS3;
  assign boundary     = (cnt == LAST);
  assign lane.DataOut = sh[NBITS-1];

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      hsS1            <= 1'b0;
      hsS2            <= 1'b0;
      hsS3            <= 1'b0;
      sh              <= '0;
      cnt             <= LAST;
      hold            <= '0;
      holdValid       <= 1'b0;
      armed           <= 1'b0;
      lane.word_start <= 1'b0;
      lane.underrun   <= 1'b0;
      lane.overrun    <= 1'b0;
    end else begin
      hsS1 <= lane.handshake;
      hsS2 <= hsS1;
      hsS3 <= hsS2;

      if (boundary) begin
        sh              <= holdValid ? hold : IDLE_WORD;
        cnt             <= '0;
        lane.word_start <= 1'b1;
        lane.underrun   <= ~holdValid & armed;
      end else begin
        sh              <= sh << 1;
        cnt             <= cnt + CW'(1);
        lane.word_start <= 1'b0;
        lane.underrun   <= 1'b0;
      end

      // A capture on the boundary cycle refills hold after the shifter took the old word.
      if (cap) begin
        hold      <= lane.DataIn;
        holdValid <= 1'b1;
        armed     <= 1'b1;
      end else if (boundary) begin
        holdValid <= 1'b0;
      end

      lane.overrun <= cap & holdValid & ~boundary;
    end
  end

`ifdef SER_ERR_CNT_EN
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      lane.underrun_cnt <= 8'h00;
    end else if (boundary && !holdValid && armed && (lane.underrun_cnt != 8'hFF)) begin
      lane.underrun_cnt <= lane.underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ldtu_ser_lane.sv
// Directed bench for ldtu_ser_lane: frames are collected bit by bit and compared to hand-computed words.
// Counter checks are compiled in only when SER_ERR_CNT_EN is defined.
module tb_ldtu_ser_lane;

  localparam logic [31:0] IDLE = 32'hEAAAAAAA;

  logic clock = 1'b0;
  logic rst_b = 1'b0;
  int   nCmp  = 0;
  int   nErr  = 0;

  ldtu_ser_lane_if #(.NBITS(32)) lane ();

  ldtu_ser_lane #(.NBITS(32), .IDLE_WORD(IDLE)) dut (
    .clock (clock),
    .rst_b (rst_b),
    .lane  (lane.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCmp++;
    if (obs !== expv) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic pulse(input logic [31:0] w);
    lane.DataIn    = w;
    lane.handshake = 1'b1;
    repeat (4) @(negedge clock);
    lane.handshake = 1'b0;
  endtask

  // Advances from the last bit of a frame (or reset release) through one full frame.
  task automatic collect(output logic [31:0] w, output logic un, output int gap,
                         output int ovr, output int wsMid);
    gap   = 0;
    ovr   = 0;
    wsMid = 0;
    @(negedge clock);
    while (!lane.word_start && gap < 40) begin
      @(negedge clock);
      gap++;
    end
    w  = {31'b0, lane.DataOut};
    un = lane.underrun;
    if (lane.overrun) ovr++;
    for (int b = 1; b < 32; b++) begin
      @(negedge clock);
      w = {w[30:0], lane.DataOut};
      if (lane.overrun)    ovr++;
      if (lane.word_start) wsMid++;
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] expW, input logic expUn,
                             input int expOvr);
    logic [31:0] w;
    logic        un;
    int          gap, ovr, wsMid;
    collect(w, un, gap, ovr, wsMid);
    chk({tag, "_gap"},   32'(gap),   32'd0);
    chk({tag, "_word"},  w,          expW);
    chk({tag, "_under"}, {31'b0, un}, {31'b0, expUn});
    chk({tag, "_over"},  32'(ovr),   32'(expOvr));
    chk({tag, "_wsmid"}, 32'(wsMid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] t3Words [4];
    t3Words[0] = 32'hA5A5A5A5;
    t3Words[1] = 32'h0F0F0F0F;
    t3Words[2] = 32'h3C3C3C3C;
    t3Words[3] = 32'h5AC3E187;

    lane.DataIn    = '0;
    lane.handshake = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_dout",  {31'b0, lane.DataOut},    32'd0);
    chk("rst_ws",    {31'b0, lane.word_start}, 32'd0);
    chk("rst_under", {31'b0, lane.underrun},   32'd0);
    chk("rst_over",  {31'b0, lane.overrun},    32'd0);
`ifdef SER_ERR_CNT_EN
    chk("rst_ucnt", {24'b0, lane.underrun_cnt}, 32'd0);
`endif
    rst_b = 1'b1;

    // Idle only, never armed
    for (int i = 0; i < 3; i++) check_frame($sformatf("t1_idle%0d", i), IDLE, 1'b0, 0);

    // Single word
    fork
      pulse(32'h12345678);
      begin
        check_frame("t2_cap",  IDLE,          1'b0, 0);
        check_frame("t2_data", 32'h12345678,  1'b0, 0);
        check_frame("t2_idle", IDLE,          1'b1, 0);
      end
    join

    // Continuous stream, one word per frame
    fork
      for (int i = 0; i < 4; i++) begin
        pulse(t3Words[i]);
        repeat (28) @(negedge clock);
      end
      begin
        check_frame("t3_lead", IDLE, 1'b1, 0);
        for (int i = 0; i < 4; i++) check_frame($sformatf("t3_d%0d", i), t3Words[i], 1'b0, 0);
      end
    join

    // Two words in one frame: second overwrites first
    fork
      begin
        pulse(32'h11111111);
        repeat (4) @(negedge clock);
        pulse(32'h22222222);
      end
      begin
        check_frame("t4_cap",  IDLE,         1'b1, 1);
        check_frame("t4_data", 32'h22222222, 1'b0, 0);
        check_frame("t4_idle", IDLE,         1'b1, 0);
      end
    join

    // Second capture lands exactly on the boundary
    fork
      begin
        pulse(32'hCAFEBABE);
        repeat (26) @(negedge clock);
        pulse(32'hDEADBEEF);
      end
      begin
        check_frame("t5_cap",   IDLE,         1'b1, 0);
        check_frame("t5_old",   32'hCAFEBABE, 1'b0, 0);
        check_frame("t5_new",   32'hDEADBEEF, 1'b0, 0);
        check_frame("t5_idle",  IDLE,         1'b1, 0);
      end
    join

    // Reset in the middle of a data word
    fork
      pulse(32'hFFFFFFFF);
      check_frame("t6_cap", IDLE, 1'b1, 0);
    join
    @(negedge clock);
    chk("t6_ws", {31'b0, lane.word_start}, 32'd1);
    repeat (13) @(negedge clock);
    chk("t6_bit13", {31'b0, lane.DataOut}, 32'd1);
    rst_b = 1'b0;
    #1;
    chk("t6_rst_dout", {31'b0, lane.DataOut},    32'd0);
    chk("t6_rst_ws",   {31'b0, lane.word_start}, 32'd0);
    repeat (2) @(negedge clock);
    rst_b = 1'b1;
    check_frame("t6_post0", IDLE, 1'b0, 0);
    check_frame("t6_post1", IDLE, 1'b0, 0);

`ifdef SER_ERR_CNT_EN
    chk("t6_ucnt0", {24'b0, lane.underrun_cnt}, 32'd0);
    fork
      pulse(32'h600DF00D);
      check_frame("t7_cap", IDLE, 1'b0, 0);
    join
    check_frame("t7_data", 32'h600DF00D, 1'b0, 0);
    check_frame("t7_u1",   IDLE,         1'b1, 0);
    chk("t7_ucnt1", {24'b0, lane.underrun_cnt}, 32'd1);
    begin
      logic [31:0] w;
      logic        un;
      int          gap, ovr, wsMid;
      for (int i = 0; i < 299; i++) collect(w, un, gap, ovr, wsMid);
      chk("t7_u300", {31'b0, un}, 32'd1);
    end
    chk("t7_ucnt_sat", {24'b0, lane.underrun_cnt}, 32'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
